// File: rtl/amoled_row_scheduler.sv
// AMOLED frame sequencer: per-row init/compensate/scan with guard gaps, then a panel-wide emission window.
// Optional `EM_PWM_EN adds an em_duty input that PWM-modulates vem2 during emission.
module amoled_row_scheduler #(
  parameter int ROWS   = 8,
  parameter int ROW_W  = 3,
  parameter int T_INIT = 20,
  parameter int T_COMP = 40,
  parameter int T_SCAN = 10,
  parameter int T_GAP  = 2,
  parameter int T_EMIT = 1000,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef EM_PWM_EN
  input  logic [7:0]       em_duty,
`endif
  output logic             busy,
  output logic             frame_done,
  output logic [ROW_W-1:0] row_addr,
  output logic             data_ld,
  output logic             vinit,
  output logic             vcomp,
  output logic             vscan,
  output logic             vem1,
  output logic             vem2
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_GAP1 = 3'd2,
    ST_COMP = 3'd3,
    ST_GAP2 = 3'd4,
    ST_SCAN = 3'd5,
    ST_GAP3 = 3'd6,
    ST_EMIT = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_INIT   = CNT_W'(T_INIT - 1);
  localparam logic [CNT_W-1:0] L_COMP   = CNT_W'(T_COMP - 1);
  localparam logic [CNT_W-1:0] L_SCAN   = CNT_W'(T_SCAN - 1);
  localparam logic [CNT_W-1:0] L_GAP    = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] L_EMIT   = CNT_W'(T_EMIT - 1);
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t           state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [ROW_W-1:0] row_r, row_n;
  logic             em2_s;

  // Counter preload for a phase: a phase of T cycles starts at T-1 and exits at 0.
  function automatic logic [CNT_W-1:0] phase_load(input state_t s);
    case (s)
      ST_INIT: phase_load = L_INIT;
      ST_GAP1: phase_load = L_GAP;
      ST_COMP: phase_load = L_COMP;
      ST_GAP2: phase_load = L_GAP;
      ST_SCAN: phase_load = L_SCAN;
      ST_GAP3: phase_load = L_GAP;
      ST_EMIT: phase_load = L_EMIT;
      default: phase_load = CNT_ZERO;
    endcase
  endfunction

  // Next-state, phase counter and row address logic.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    row_n   = row_r;
    case (state_r)
      ST_IDLE: begin
        row_n = ROW_ZERO;
        if (start) begin
          state_n = ST_INIT;
          cnt_n   = L_INIT;
        end else begin
          state_n = ST_IDLE;
          cnt_n   = CNT_ZERO;
        end
      end
      default: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_n = cnt_r - CNT_ONE;
        end else begin
          case (state_r)
            ST_INIT: state_n = ST_GAP1;
            ST_GAP1: state_n = ST_COMP;
            ST_COMP: state_n = ST_GAP2;
            ST_GAP2: state_n = ST_SCAN;
            ST_SCAN: state_n = ST_GAP3;
            ST_GAP3: begin
              if (row_r < ROW_LAST) begin
                row_n   = row_r + ROW_W'(1);
                state_n = ST_INIT;
              end else begin
                state_n = ST_EMIT;
              end
            end
            ST_EMIT: begin
              state_n = ST_IDLE;
              row_n   = ROW_ZERO;
            end
            default: state_n = ST_IDLE;
          endcase
          cnt_n = phase_load(state_n);
        end
      end
    endcase
  end

`ifdef EM_PWM_EN
  logic [7:0] pwm_r, pwm_n, duty_r, duty_n;
  logic       em_entry_s;

  // PWM counter restarts and duty is captured on the cycle emission begins.
  always_comb begin
    em_entry_s = (state_n == ST_EMIT) && (state_r != ST_EMIT);
    if (em_entry_s) begin
      pwm_n  = 8'd0;
      duty_n = em_duty;
    end else begin
      pwm_n  = pwm_r + 8'd1;
      duty_n = duty_r;
    end
    em2_s = (state_n == ST_EMIT) && (pwm_n < duty_n);
  end

  // PWM counter and held duty registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_r  <= 8'd0;
      duty_r <= 8'd0;
    end else begin
      pwm_r  <= pwm_n;
      duty_r <= duty_n;
    end
  end
`else
  assign em2_s = (state_n == ST_EMIT);
`endif

  // State registers; outputs are decoded from the next state so every output is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      row_r      <= ROW_ZERO;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      row_addr   <= ROW_ZERO;
      data_ld    <= 1'b0;
      vinit      <= 1'b0;
      vcomp      <= 1'b0;
      vscan      <= 1'b0;
      vem1       <= 1'b0;
      vem2       <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      row_r      <= row_n;
      busy       <= (state_n != ST_IDLE);
      frame_done <= (state_r == ST_EMIT) && (state_n == ST_IDLE);
      row_addr   <= row_n;
      data_ld    <= (state_n == ST_SCAN) && (state_r != ST_SCAN);
      vinit      <= (state_n == ST_INIT);
      vcomp      <= (state_n == ST_COMP);
      vscan      <= (state_n == ST_SCAN);
      vem1       <= (state_n == ST_EMIT);
      vem2       <= em2_s;
    end
  end

endmodule
